// File: rtl/apb_slave.sv
// APB completer: NUM_REGS x 32-bit register file with fixed wait states,
// slave-error reporting and a saturating error counter in register 1.
module apb_slave #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0016
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o
);

  // state  | meaning
  // IDLE   | waiting for a SETUP phase (psel=1, penable=0)
  // WAIT   | ACCESS phase, wait-state down-counter running
  // DONE   | pready_o high for this single cycle, commit at its closing edge
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int          IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(NUM_REGS * 4);
  localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [31:0]      addr_q;
  logic             wr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      err_cnt;
  logic [31:0]      regs [NUM_REGS];

  logic [31:0]      dec_addr;
  logic             dec_wr;
  logic [IDX_W-1:0] idx;
  logic             acc_err;
  logic [31:0]      rd_val;

  // With zero wait states DONE is entered straight from IDLE, so decode the live bus there.
  always_comb begin
    dec_addr = (state == S_IDLE) ? paddr_i  : addr_q;
    dec_wr   = (state == S_IDLE) ? pwrite_i : wr_q;
    idx      = dec_addr[IDX_W+1:2];
    acc_err  = (dec_addr[1:0] != 2'b00) || (dec_addr >= ADDR_LIMIT) ||
               (dec_wr && (idx == IDX_W'(0)));
    rd_val   = 32'h0;
    if (!acc_err) begin
      if (idx == IDX_W'(0))      rd_val = ID_VALUE;
      else if (idx == IDX_W'(1)) rd_val = err_cnt;
      else                       rd_val = regs[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      addr_q    <= 32'h0;
      wr_q      <= 1'b0;
      wdata_q   <= 32'h0;
      err_cnt   <= 32'h0;
      pready_o  <= 1'b0;
      prdata_o  <= 32'h0;
      pslverr_o <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
    end else begin
      pready_o  <= 1'b0;
      prdata_o  <= 32'h0;
      pslverr_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (psel_i && !penable_i) begin
            addr_q  <= paddr_i;
            wr_q    <= pwrite_i;
            wdata_q <= pwdata_i;
            if (WAIT_CYCLES == 0) begin
              state     <= S_DONE;
              pready_o  <= 1'b1;
              pslverr_o <= acc_err;
              prdata_o  <= dec_wr ? 32'h0 : rd_val;
            end else begin
              cnt   <= WAIT_LOAD;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!psel_i) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end else if (penable_i) begin
            if (cnt == 4'd1) begin
              cnt       <= 4'd0;
              state     <= S_DONE;
              pready_o  <= 1'b1;
              pslverr_o <= acc_err;
              prdata_o  <= dec_wr ? 32'h0 : rd_val;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (pslverr_o) begin
            if (err_cnt != 32'hFFFF_FFFF) err_cnt <= err_cnt + 32'd1;
          end else if (wr_q) begin
            if (idx == IDX_W'(1))      err_cnt   <= 32'h0;
            else if (idx != IDX_W'(0)) regs[idx] <= wdata_q;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave.sv
// Bench for apb_slave: directed vector table, multi-cycle corner sequences and
// randomized transfers against a behavioural register-file model.
module tb_apb_slave;

  localparam logic [31:0] ID = 32'hA5B0_0016;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  psel = '0, penable = '0, pwrite = '0;
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [1:0]  pready, pslverr;
  logic [31:0] prdata [2];

  int checks = 0;
  int fails  = 0;

  // model state: index 0 = zero-wait instance, 1 = two-wait instance
  logic [31:0] mregs [2][16];
  logic [31:0] mcnt [2];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  vec_t tbl [11];

  always #5 clk = ~clk;

  apb_slave #(.NUM_REGS(16), .WAIT_CYCLES(0), .ID_VALUE(ID)) u_dut0 (
    .clk(clk), .reset(reset), .psel_i(psel[0]), .penable_i(penable[0]),
    .paddr_i(paddr[0]), .pwrite_i(pwrite[0]), .pwdata_i(pwdata[0]),
    .pready_o(pready[0]), .prdata_o(prdata[0]), .pslverr_o(pslverr[0]));

  apb_slave #(.NUM_REGS(16), .WAIT_CYCLES(2), .ID_VALUE(ID)) u_dut2 (
    .clk(clk), .reset(reset), .psel_i(psel[1]), .penable_i(penable[1]),
    .paddr_i(paddr[1]), .pwrite_i(pwrite[1]), .pwdata_i(pwdata[1]),
    .pready_o(pready[1]), .prdata_o(prdata[1]), .pslverr_o(pslverr[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 32'h0;
      for (int r = 0; r < 16; r++) mregs[d][r] = 32'h0;
    end
  endtask

  task automatic model_op(input int n, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, output logic [31:0] rd, output bit err);
    int idx;
    idx = int'(addr[5:2]);
    err = (addr[1:0] != 2'b00) || (addr >= 32'd64) || (wr && idx == 0);
    rd  = 32'h0;
    if (err) begin
      if (mcnt[n] != 32'hFFFF_FFFF) mcnt[n] = mcnt[n] + 1;
    end else if (wr) begin
      if (idx == 1) mcnt[n] = 32'h0;
      else          mregs[n][idx] = data;
    end else begin
      rd = (idx == 0) ? ID : (idx == 1) ? mcnt[n] : mregs[n][idx];
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the completion cycle.
  task automatic xfer(input int n, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rd, output bit err, output int waits);
    psel[n] = 1'b1; penable[n] = 1'b0; pwrite[n] = wr; paddr[n] = addr; pwdata[n] = data;
    @(negedge clk);
    penable[n] = 1'b1;
    paddr[n]   = $urandom;
    pwdata[n]  = $urandom;
    pwrite[n]  = 1'($urandom);
    waits = 0;
    while (pready[n] !== 1'b1 && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 40) check("pready_timeout", 32'(pready[n]), 32'h1);
    rd  = prdata[n];
    err = pslverr[n];
    @(negedge clk);
    check("pready_single_pulse", 32'(pready[n]), 32'h0);
    psel[n] = 1'b0; penable[n] = 1'b0;
  endtask

  task automatic xfer_check(input int n, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_rd,
                            input bit exp_err, input string name);
    logic [31:0] rd;
    bit          err;
    int          waits;
    xfer(n, wr, addr, data, rd, err, waits);
    check({name, "_waits"}, 32'(waits), (n == 0) ? 32'd0 : 32'd2);
    check({name, "_pslverr"}, 32'(err), 32'(exp_err));
    if (!wr || exp_err) check({name, "_prdata"}, rd, exp_rd);
  endtask

  task automatic model_xfer(input int n, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input string name);
    logic [31:0] exp_rd;
    bit          exp_err;
    model_op(n, wr, addr, data, exp_rd, exp_err);
    xfer_check(n, wr, addr, data, exp_rd, exp_err, name);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, 15) * 4);
    else if (r == 7) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    else if (r == 8) return 32'(64 + $urandom_range(0, 100) * 4);
    else             return $urandom;
  endfunction

  initial begin
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_err;

    tbl[0]  = '{1'b0, 32'h04, 32'h0,         32'h0,         1'b0};
    tbl[1]  = '{1'b0, 32'h08, 32'h0,         32'h0,         1'b0};
    tbl[2]  = '{1'b1, 32'h08, 32'hDEAD_BEEF, 32'h0,         1'b0};
    tbl[3]  = '{1'b0, 32'h08, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[4]  = '{1'b0, 32'h00, 32'h0,         ID,            1'b0};
    tbl[5]  = '{1'b1, 32'h00, 32'h1234_5678, 32'h0,         1'b1};
    tbl[6]  = '{1'b0, 32'h41, 32'h0,         32'h0,         1'b1};
    tbl[7]  = '{1'b0, 32'h40, 32'h0,         32'h0,         1'b1};
    tbl[8]  = '{1'b0, 32'h04, 32'h0,         32'd3,         1'b0};
    tbl[9]  = '{1'b1, 32'h04, 32'hFFFF_0000, 32'h0,         1'b0};
    tbl[10] = '{1'b0, 32'h04, 32'h0,         32'h0,         1'b0};

    for (int n = 0; n < 2; n++) begin paddr[n] = '0; pwdata[n] = '0; end
    model_reset();

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_pready", 32'(pready), 32'h0);
    end
    check("reset_prdata", prdata[1], 32'h0);
    check("reset_pslverr", 32'(pslverr), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      model_op(1, tbl[i].wr, tbl[i].addr, tbl[i].wdata, exp_rd, exp_err);
      xfer_check(1, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].err,
                 $sformatf("tbl%0d", i));
    end

    // psel drops in the first ACCESS cycle of a write of 5 to 0xC
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h0C; pwdata[1] = 32'h5;
    @(negedge clk);
    psel[1] = 1'b0; penable[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("abort_pready", 32'(pready[1]), 32'h0);
      @(negedge clk);
    end
    penable[1] = 1'b0;
    model_xfer(1, 1'b0, 32'h0C, 32'h0, "abort_rd_c");
    model_xfer(1, 1'b0, 32'h04, 32'h0, "abort_errcnt");

    // stray penable without SETUP must not start a transfer
    psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 32'h14; pwdata[1] = 32'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_penable_pready", 32'(pready[1]), 32'h0);
    end
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    model_xfer(1, 1'b0, 32'h14, 32'h0, "stray_rd_14");

    // back-to-back alternating writes/reads on the zero-wait instance
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      model_xfer(0, 1'b1, 32'((2 + i) * 4), d, $sformatf("b2b_wr%0d", i));
      model_xfer(0, 1'b0, 32'((2 + i) * 4), 32'h0, $sformatf("b2b_rd%0d", i));
    end

    for (int i = 0; i < 60; i++) begin
      int n;
      n = i % 2;
      model_xfer(n, 1'($urandom), rand_addr(), $urandom, $sformatf("rand%0d_dut%0d", i, n));
    end
    for (int r = 0; r < 16; r++) model_xfer(1, 1'b0, 32'(r * 4), 32'h0, $sformatf("sweep%0d", r));

    // reset asserted while a write to 0x10 is in WAIT
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h10; pwdata[1] = 32'hCAFE_F00D;
    @(negedge clk);
    penable[1] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_pready", 32'(pready[1]), 32'h0);
    check("midreset_prdata", prdata[1], 32'h0);
    check("midreset_pslverr", 32'(pslverr[1]), 32'h0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_xfer(1, 1'b0, 32'h10, 32'h0, "post_reset_rd_10");
    model_xfer(1, 1'b0, 32'h04, 32'h0, "post_reset_errcnt");
    model_xfer(0, 1'b0, 32'h08, 32'h0, "post_reset_dut0_rd_8");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
